// File: rtl/fft_256pt_reorder.sv
// Output reorder buffer for the radix-4 256-point FFT: frames arrive in base-4
// digit-reversed order, are stored in a ping-pong RAM and replayed in natural bin order.
module fft_256pt_reorder #(
    parameter int DATA_W = 16,
    parameter int LOG4_N = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic signed [DATA_W-1:0] data_r_in,
    input  logic signed [DATA_W-1:0] data_i_in,
    output logic signed [DATA_W-1:0] data_r_out,
    output logic signed [DATA_W-1:0] data_i_out,
    output logic                     out_valid,
    output logic                     out_sof,
    output logic                     out_last,
    output logic                     sof_err
);

    localparam int AW = 2 * LOG4_N;
    localparam int N  = 1 << AW;
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic { W_IDLE = 1'b0, W_FILL = 1'b1 } wstate_t;
    typedef enum logic { R_IDLE = 1'b0, R_READ = 1'b1 } rstate_t;

    function automatic logic [AW-1:0] digit_rev(input logic [AW-1:0] x);
        logic [AW-1:0] r;
        r = '0;
        for (int d = 0; d < LOG4_N; d++) begin
            r[2*d +: 2] = x[2*(LOG4_N-1-d) +: 2];
        end
        return r;
    endfunction

    logic [2*DATA_W-1:0] mem [2*N];

    wstate_t       wstate, wstate_nxt;
    logic [AW-1:0] wcnt, wcnt_nxt;
    logic          wbank;
    logic [1:0]    full;
    logic          wr_en, frame_done, restart;
    logic [AW-1:0] wr_addr;

    rstate_t       rstate, rstate_nxt;
    logic [AW-1:0] rcnt, rcnt_nxt;
    logic          rbank, rbank_nxt;
    logic          rd_en, rd_done;
    logic [1:0]    set_mask, clr_mask;

    logic signed [DATA_W-1:0] data_r_p1, data_i_p1;
    logic                     vld_p1, sof_p1, last_p1;

    // Writer: stores each sample at the natural-order slot of its bin
    always_comb begin
        wstate_nxt = wstate;
        wcnt_nxt   = wcnt;
        wr_en      = 1'b0;
        wr_addr    = digit_rev(wcnt);
        frame_done = 1'b0;
        restart    = 1'b0;
        case (wstate)
            W_IDLE: begin
                if (in_valid && in_sof) begin
                    wr_en      = 1'b1;
                    wcnt_nxt   = AW'(1);
                    wstate_nxt = W_FILL;
                end
            end
            W_FILL: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (in_sof) begin
                        // Early frame start: abandon the partial frame, reuse the bank.
                        restart  = 1'b1;
                        wr_addr  = '0;
                        wcnt_nxt = AW'(1);
                    end else if (wcnt == LAST) begin
                        frame_done = 1'b1;
                        wcnt_nxt   = '0;
                        wstate_nxt = W_IDLE;
                    end else begin
                        wcnt_nxt = wcnt + AW'(1);
                    end
                end
            end
            default: wstate_nxt = W_IDLE;
        endcase
    end

    // Reader: the oldest full bank is the one the writer is not filling, unless both are full
    always_comb begin
        rstate_nxt = rstate;
        rcnt_nxt   = rcnt;
        rbank_nxt  = rbank;
        rd_en      = 1'b0;
        rd_done    = 1'b0;
        case (rstate)
            R_IDLE: begin
                if (|full) begin
                    rstate_nxt = R_READ;
                    rcnt_nxt   = '0;
                    rbank_nxt  = full[wbank] ? wbank : ~wbank;
                end
            end
            R_READ: begin
                rd_en = 1'b1;
                if (rcnt == LAST) begin
                    rd_done  = 1'b1;
                    rcnt_nxt = '0;
                    if (full[~rbank]) begin
                        rbank_nxt = ~rbank;
                    end else begin
                        rstate_nxt = R_IDLE;
                    end
                end else begin
                    rcnt_nxt = rcnt + AW'(1);
                end
            end
            default: rstate_nxt = R_IDLE;
        endcase
    end

    assign set_mask = {frame_done & wbank, frame_done & ~wbank};
    assign clr_mask = {rd_done & rbank, rd_done & ~rbank};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate  <= W_IDLE;
            wcnt    <= '0;
            wbank   <= 1'b0;
            full    <= 2'b00;
            sof_err <= 1'b0;
            rstate  <= R_IDLE;
            rcnt    <= '0;
            rbank   <= 1'b0;
        end else begin
            wstate  <= wstate_nxt;
            wcnt    <= wcnt_nxt;
            wbank   <= wbank ^ frame_done;
            full    <= (full & ~clr_mask) | set_mask;
            sof_err <= restart;
            rstate  <= rstate_nxt;
            rcnt    <= rcnt_nxt;
            rbank   <= rbank_nxt;
        end
    end

    // Write port of the dual-port RAM; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wbank, wr_addr}] <= {data_r_in, data_i_in};
        end
    end

    // Stage p1: registered read port and frame markers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r_p1 <= '0;
            data_i_p1 <= '0;
            vld_p1    <= 1'b0;
            sof_p1    <= 1'b0;
            last_p1   <= 1'b0;
        end else if (rd_en) begin
            data_r_p1 <= $signed(mem[{rbank, rcnt}][2*DATA_W-1:DATA_W]);
            data_i_p1 <= $signed(mem[{rbank, rcnt}][DATA_W-1:0]);
            vld_p1    <= 1'b1;
            sof_p1    <= (rcnt == '0);
            last_p1   <= (rcnt == LAST);
        end else begin
            data_r_p1 <= '0;
            data_i_p1 <= '0;
            vld_p1    <= 1'b0;
            sof_p1    <= 1'b0;
            last_p1   <= 1'b0;
        end
    end

    assign data_r_out = data_r_p1;
    assign data_i_out = data_i_p1;
    assign out_valid  = vld_p1;
    assign out_sof    = sof_p1;
    assign out_last   = last_p1;

endmodule

// File: tb/tb_fft_256pt_reorder.sv
// Directed testbench for fft_256pt_reorder: ramp frames in digit-reversed order,
// checked bin by bin in natural order with latency, framing and reset cases.
module tb_fft_256pt_reorder;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid, in_sof;
    logic signed [15:0] data_r_in, data_i_in;
    logic signed [15:0] data_r_out, data_i_out;
    logic               out_valid, out_sof, out_last, sof_err;

    fft_256pt_reorder #(.DATA_W(16), .LOG4_N(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .data_r_in(data_r_in), .data_i_in(data_i_in),
        .data_r_out(data_r_out), .data_i_out(data_i_out),
        .out_valid(out_valid), .out_sof(out_sof), .out_last(out_last),
        .sof_err(sof_err)
    );

    always #5 clk = ~clk;

    typedef struct { int r; int i; bit sof; bit last; int cyc; } obs_t;
    obs_t q[$];
    int   cyc = 0;
    int   vectors = 0, miscompares = 0;
    int   idle_bad = 0, err_cnt = 0, err_cyc = -1;
    int   last_wcyc = 0, first_wcyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled 1 time unit after each rising edge
    always @(posedge clk) begin
        #1;
        if (out_valid) begin
            q.push_back('{r: int'(data_r_out), i: int'(data_i_out),
                          sof: out_sof, last: out_last, cyc: cyc});
        end else if (data_r_out != 0 || data_i_out != 0 || out_sof || out_last) begin
            idle_bad++;
        end
        if (sof_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic int rev4(input int n);
        int r = 0;
        int x = n;
        for (int d = 0; d < 4; d++) begin
            r = r * 4 + x % 4;
            x = x / 4;
        end
        return r;
    endfunction

    task automatic chk(input logic signed [31:0] obs, input logic signed [31:0] exp,
                       input string tag);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input bit sof, input int v);
        @(negedge clk);
        in_valid  = 1'b1;
        in_sof    = sof;
        data_r_in = 16'(v);
        data_i_in = 16'(-v);
        last_wcyc = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sof   = 1'b0;
        end
    endtask

    task automatic drive_frame(input int base, input bit gap);
        for (int k = 0; k < 256; k++) begin
            send(k == 0, base + k);
            if (k == 0) first_wcyc = last_wcyc;
            if (gap) idle(1);
        end
    endtask

    task automatic wait_out(input int n, input int budget);
        int t = 0;
        while (q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        idle(8);
    endtask

    task automatic check_frame(input int base, input int wcyc, input string tag);
        int bad = 0;
        chk(q.size(), 256, {tag, "_count"});
        if (q.size() >= 256) begin
            chk(q[0].cyc, wcyc + 2, {tag, "_sof_latency"});
            chk(q[0].sof, 1, {tag, "_sof"});
            chk(q[0].r, base, {tag, "_bin0"});
            chk(q[1].r, base + 64, {tag, "_bin1_r"});
            chk(q[1].i, -(base + 64), {tag, "_bin1_i"});
            chk(q[4].r, base + 16, {tag, "_bin4"});
            chk(q[5].r, base + 80, {tag, "_bin5"});
            chk(q[255].r, base + 255, {tag, "_bin255"});
            chk(q[255].last, 1, {tag, "_last"});
            chk(q[255].cyc, wcyc + 257, {tag, "_last_latency"});
            for (int n = 0; n < 256; n++) begin
                if (q[n].r != base + rev4(n) || q[n].i != -(base + rev4(n)) ||
                    q[n].sof != (n == 0) || q[n].last != (n == 255) ||
                    q[n].cyc != q[0].cyc + n) bad++;
            end
            chk(bad, 0, {tag, "_body"});
        end
    endtask

    initial begin
        int bad;
        int t;
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; data_r_in = '0; data_i_in = '0;
        repeat (3) @(negedge clk);
        chk(out_valid, 0, "rst_valid");
        chk(data_r_out, 0, "rst_data_r");
        chk(out_sof, 0, "rst_sof");
        chk(sof_err, 0, "rst_sof_err");
        rst_n = 1'b1;

        // Samples without a frame start are dropped
        for (int k = 0; k < 20; k++) send(1'b0, 900 + k);
        idle(300);
        chk(q.size(), 0, "nosof_dropped");

        // Single contiguous ramp frame
        drive_frame(0, 1'b0);
        idle(1);
        wait_out(256, 600);
        check_frame(0, last_wcyc, "ramp");
        chk(err_cnt, 0, "ramp_no_err");
        q.delete();

        // Ramp with in_valid toggling
        drive_frame(0, 1'b1);
        wait_out(256, 600);
        check_frame(0, last_wcyc, "gapped");
        q.delete();

        // Three back-to-back frames
        drive_frame(1000, 1'b0);
        t = last_wcyc;
        drive_frame(2000, 1'b0);
        drive_frame(3000, 1'b0);
        idle(1);
        wait_out(768, 1200);
        chk(q.size(), 768, "b2b_count");
        if (q.size() >= 768) begin
            chk(q[0].cyc, t + 2, "b2b_latency");
            chk(q[256].sof, 1, "b2b_sof2");
            chk(q[256].cyc, q[255].cyc + 1, "b2b_no_bubble");
            chk(q[512].r, 3000, "b2b_f3_bin0");
            chk(q[767].last, 1, "b2b_last3");
            bad = 0;
            for (int j = 0; j < 768; j++) begin
                if (q[j].r != 1000 * (j / 256 + 1) + rev4(j % 256) ||
                    q[j].sof != (j % 256 == 0) || q[j].last != (j % 256 == 255) ||
                    q[j].cyc != q[0].cyc + j) bad++;
            end
            chk(bad, 0, "b2b_body");
        end
        q.delete();

        // Frame restarted at wcnt=100, followed by a full ramp
        err_cnt = 0;
        send(1'b1, 5000);
        for (int k = 1; k < 100; k++) send(1'b0, 5000 + k);
        drive_frame(0, 1'b0);
        idle(1);
        wait_out(256, 600);
        chk(err_cnt, 1, "restart_err_pulses");
        chk(err_cyc, first_wcyc, "restart_err_cycle");
        check_frame(0, last_wcyc, "restart");
        q.delete();

        // Reset during readout at bin 50
        drive_frame(0, 1'b0);
        idle(1);
        t = 0;
        while (q.size() < 51 && t < 600) begin
            @(negedge clk);
            t++;
        end
        chk(q.size(), 51, "midrst_reach_bin50");
        if (q.size() >= 51) chk(q[50].r, 140, "midrst_bin50");
        rst_n = 1'b0;
        #1;
        chk(out_valid, 0, "midrst_valid");
        chk(data_r_out, 0, "midrst_data_r");
        chk(data_i_out, 0, "midrst_data_i");
        chk(out_sof, 0, "midrst_sof");
        chk(out_last, 0, "midrst_last");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        q.delete();
        drive_frame(100, 1'b0);
        idle(1);
        wait_out(256, 600);
        check_frame(100, last_wcyc, "postrst");

        chk(idle_bad, 0, "idle_outputs_zero");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
